// File: rtl/cpu_pkg.sv
// Shared definitions for the accumulator CPU: default widths, opcodes and the
// control-strobe bundle exchanged between the controller and the datapath.
package cpu_pkg;

   localparam int ADDR_W_DEFAULT = 5;
   localparam int DATA_W_DEFAULT = 8;

   // Opcodes occupy the top three bits of IR; only the controller decodes them.
   localparam logic [2:0] OP_LOAD  = 3'd0;
   localparam logic [2:0] OP_ADD   = 3'd1;
   localparam logic [2:0] OP_STORE = 3'd2;
   localparam logic [2:0] OP_JUMP  = 3'd3;

   typedef struct packed {
      logic rd_mem;
      logic wr_mem;
      logic ld_ac;
      logic ld_ir;
      logic ld_pc;
      logic inc_pc;
      logic pass;
      logic add;
   } strobes_t;

endpackage

// File: rtl/cpu_ram.sv
// Single-port program/data RAM: one synchronous write port and a combinational
// read port, so a word written at one edge is visible in the following cycle.
module cpu_ram
   import cpu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [DATA_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/cpu_datapath.sv
// Accumulator CPU datapath: PC, IR, AC, carry, address mux, ALU, RAM write-port
// arbitration and a sticky checker for illegal control-strobe combinations.
module cpu_datapath
   import cpu_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int DATA_W = DATA_W_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rd_mem,
   input  logic              wr_mem,
   input  logic              ld_ac,
   input  logic              ld_ir,
   input  logic              ld_pc,
   input  logic              inc_pc,
   input  logic              pass,
   input  logic              add,
   input  logic              init_we,
   input  logic [ADDR_W-1:0] init_addr,
   input  logic [DATA_W-1:0] init_data,
   output logic [DATA_W-1:0] ir,
   output logic [ADDR_W-1:0] pc,
   output logic [DATA_W-1:0] ac,
   output logic              carry,
   output logic              ctrl_err
);

   strobes_t          s;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] ram_rdata;
   logic [DATA_W-1:0] bus;
   logic [DATA_W:0]   sum;
   logic [DATA_W-1:0] alu;
   logic              alu_c;
   logic              err_now;
   logic              ram_we;
   logic [ADDR_W-1:0] ram_waddr;
   logic [DATA_W-1:0] ram_wdata;

   assign s = '{rd_mem: rd_mem, wr_mem: wr_mem, ld_ac: ld_ac, ld_ir: ld_ir,
                ld_pc: ld_pc, inc_pc: inc_pc, pass: pass, add: add};

   // During a fetch the RAM is addressed by PC, otherwise by the IR operand.
   assign addr = s.ld_ir ? pc : ir[ADDR_W-1:0];
   assign bus  = s.rd_mem ? ram_rdata : '0;
   assign sum  = {1'b0, ac} + {1'b0, bus};

   always_comb begin
      alu   = ac;
      alu_c = 1'b0;
      if (s.add) begin
         {alu_c, alu} = sum;
      end else if (s.pass) begin
         alu = bus;
      end
   end

   assign err_now = (s.rd_mem & s.wr_mem)
                  | (s.pass & s.add)
                  | (s.ld_ac & ~(s.pass | s.add))
                  | (s.ld_ir & s.wr_mem)
                  | (s.ld_ir & ~s.rd_mem)
                  | (s.ld_pc & s.inc_pc);

   // Test-load always wins; a wr_mem colliding with rd_mem is dropped.
   always_comb begin
      ram_we    = 1'b0;
      ram_waddr = addr;
      ram_wdata = ac;
      if (init_we) begin
         ram_we    = 1'b1;
         ram_waddr = init_addr;
         ram_wdata = init_data;
      end else if (s.wr_mem && !s.rd_mem && !reset) begin
         ram_we = 1'b1;
      end
   end

   cpu_ram #(
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W)
   ) u_ram (
      .clk  (clk),
      .we   (ram_we),
      .waddr(ram_waddr),
      .wdata(ram_wdata),
      .raddr(addr),
      .rdata(ram_rdata)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         pc       <= '0;
         ir       <= '0;
         ac       <= '0;
         carry    <= 1'b0;
         ctrl_err <= 1'b0;
      end else begin
         if (s.ld_ac) begin
            ac <= alu;
            if (s.add) begin
               carry <= alu_c;
            end
         end
         if (s.ld_ir) begin
            ir <= bus;
         end
         if (s.ld_pc) begin
            pc <= ir[ADDR_W-1:0];
         end else if (s.inc_pc) begin
            pc <= pc + 1'b1;
         end
         ctrl_err <= ctrl_err | err_now;
      end
   end

endmodule

// File: tb/tb_cpu_datapath.sv
// Self-checking bench for cpu_datapath: directed test-plan scenarios followed by
// randomized strobe traffic compared against a behavioural model.
module tb_cpu_datapath;

   localparam logic [7:0] S_RD   = 8'h80;
   localparam logic [7:0] S_WR   = 8'h40;
   localparam logic [7:0] S_LDAC = 8'h20;
   localparam logic [7:0] S_LDIR = 8'h10;
   localparam logic [7:0] S_LDPC = 8'h08;
   localparam logic [7:0] S_INC  = 8'h04;
   localparam logic [7:0] S_PASS = 8'h02;
   localparam logic [7:0] S_ADD  = 8'h01;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       rd_mem = 1'b0, wr_mem = 1'b0, ld_ac = 1'b0, ld_ir = 1'b0;
   logic       ld_pc = 1'b0, inc_pc = 1'b0, pass = 1'b0, add = 1'b0;
   logic       init_we = 1'b0;
   logic [4:0] init_addr = '0;
   logic [7:0] init_data = '0;
   logic [7:0] ir;
   logic [4:0] pc;
   logic [7:0] ac;
   logic       carry;
   logic       ctrl_err;

   int checks = 0;
   int errors = 0;

   // Behavioural model state
   logic [7:0] m_mem [32];
   logic [4:0] m_pc = '0;
   logic [7:0] m_ir = '0;
   logic [7:0] m_ac = '0;
   logic       m_c = 1'b0;
   logic       m_err = 1'b0;

   cpu_datapath dut (
      .clk(clk), .reset(reset),
      .rd_mem(rd_mem), .wr_mem(wr_mem), .ld_ac(ld_ac), .ld_ir(ld_ir),
      .ld_pc(ld_pc), .inc_pc(inc_pc), .pass(pass), .add(add),
      .init_we(init_we), .init_addr(init_addr), .init_data(init_data),
      .ir(ir), .pc(pc), .ac(ac), .carry(carry), .ctrl_err(ctrl_err)
   );

   always #5 clk = ~clk;

   task automatic model_step();
      int a, b, sum;
      logic [7:0] nac, nir;
      logic [4:0] npc;
      logic nc, nerr;
      if (reset) begin
         m_pc = '0; m_ir = '0; m_ac = '0; m_c = 1'b0; m_err = 1'b0;
         if (init_we) m_mem[init_addr] = init_data;
         return;
      end
      a = ld_ir ? int'(m_pc) : int'(m_ir[4:0]);
      b = rd_mem ? int'(m_mem[a]) : 0;
      nac = m_ac;
      nc  = m_c;
      if (ld_ac) begin
         if (add) begin
            sum = int'(m_ac) + b;
            nac = sum[7:0];
            nc  = (sum > 255);
         end else if (pass) begin
            nac = b[7:0];
         end
      end
      nir = ld_ir ? b[7:0] : m_ir;
      if (ld_pc) npc = m_ir[4:0];
      else if (inc_pc) npc = 5'((int'(m_pc) + 1) % 32);
      else npc = m_pc;
      nerr = m_err | (rd_mem & wr_mem) | (pass & add) | (ld_ac & !(pass | add))
           | (ld_ir & wr_mem) | (ld_ir & !rd_mem) | (ld_pc & inc_pc);
      if (init_we) m_mem[init_addr] = init_data;
      else if (wr_mem && !rd_mem) m_mem[a] = m_ac;
      m_pc = npc; m_ir = nir; m_ac = nac; m_c = nc; m_err = nerr;
   endtask

   task automatic apply(input logic [7:0] st, input logic rst, input logic iwe,
                        input logic [4:0] ia, input logic [7:0] id, input string tag);
      {rd_mem, wr_mem, ld_ac, ld_ir, ld_pc, inc_pc, pass, add} = st;
      reset = rst; init_we = iwe; init_addr = ia; init_data = id;
      model_step();
      @(posedge clk);
      #1;
      $display("%s: strobes=%b reset=%b init=%b@%h=%h -> pc=%h ir=%h ac=%h carry=%b err=%b",
               tag, st, rst, iwe, ia, id, pc, ir, ac, carry, ctrl_err);
   endtask

   task automatic test_reset();
      for (int i = 0; i < 32; i++)
         apply(8'h00, 1'b1, 1'b1, 5'(i), 8'($urandom), "preload");
      apply(8'hFF, 1'b1, 1'b0, '0, '0, "reset_strobes");
      checks++;
      if ({pc, ir, ac, carry, ctrl_err} !== 23'd0) begin
         errors++;
         $display("FAIL reset_state: got pc=%h ir=%h ac=%h carry=%b err=%b, need all zero",
                  pc, ir, ac, carry, ctrl_err);
      end
   endtask

   task automatic test_fetch();
      apply(8'h00, 1'b1, 1'b1, 5'd0, 8'h05, "init0");
      apply(8'h00, 1'b1, 1'b1, 5'd5, 8'h2A, "init5");
      apply(S_RD | S_LDIR | S_INC, 1'b0, 1'b0, '0, '0, "fetch");
      checks++;
      if (ir !== 8'h05 || pc !== 5'd1) begin
         errors++;
         $display("FAIL fetch: got ir=%h pc=%h, need ir=05 pc=01", ir, pc);
      end
   endtask

   task automatic test_load_add_store();
      apply(S_RD | S_PASS | S_LDAC, 1'b0, 1'b0, '0, '0, "load");
      checks++;
      if (ac !== 8'h2A) begin
         errors++; $display("FAIL load: got ac=%h, need 2a", ac);
      end
      apply(8'h00, 1'b0, 1'b1, 5'd5, 8'hF0, "init5");
      apply(S_RD | S_ADD | S_LDAC, 1'b0, 1'b0, '0, '0, "add");
      checks++;
      if (ac !== 8'h1A || carry !== 1'b1) begin
         errors++; $display("FAIL add_carry: got ac=%h carry=%b, need ac=1a carry=1", ac, carry);
      end
      apply(S_WR, 1'b0, 1'b0, '0, '0, "store");
      checks++;
      if (dut.u_ram.mem[5] !== 8'h1A) begin
         errors++; $display("FAIL store: got ram[5]=%h, need 1a", dut.u_ram.mem[5]);
      end
      apply(S_RD | S_PASS | S_LDAC, 1'b0, 1'b0, '0, '0, "readback");
      checks++;
      if (ac !== 8'h1A || carry !== 1'b1 || ctrl_err !== 1'b0) begin
         errors++;
         $display("FAIL readback: got ac=%h carry=%b err=%b, need ac=1a carry=1 err=0",
                  ac, carry, ctrl_err);
      end
   endtask

   task automatic test_jump_priority();
      apply(8'h00, 1'b0, 1'b1, 5'd1, 8'h1F, "init1");
      apply(S_RD | S_LDIR, 1'b0, 1'b0, '0, '0, "fetch_jump");
      apply(S_LDPC | S_INC, 1'b0, 1'b0, '0, '0, "jump_inc");
      checks++;
      if (pc !== 5'h1F || ctrl_err !== 1'b1) begin
         errors++; $display("FAIL jump_priority: got pc=%h err=%b, need pc=1f err=1", pc, ctrl_err);
      end
   endtask

   task automatic test_pc_wrap();
      apply(S_INC, 1'b0, 1'b0, '0, '0, "wrap");
      checks++;
      if (pc !== 5'h00 || ctrl_err !== 1'b1) begin
         errors++; $display("FAIL pc_wrap: got pc=%h err=%b, need pc=00 err=1", pc, ctrl_err);
      end
   endtask

   task automatic test_conflict();
      apply(8'h00, 1'b1, 1'b0, '0, '0, "reset");
      apply(S_RD | S_LDIR, 1'b0, 1'b0, '0, '0, "fetch");
      checks++;
      if (ir !== 8'h05 || ctrl_err !== 1'b0) begin
         errors++; $display("FAIL conflict_setup: got ir=%h err=%b, need ir=05 err=0", ir, ctrl_err);
      end
      apply(S_RD | S_WR, 1'b0, 1'b0, '0, '0, "rd_wr");
      checks++;
      if (dut.u_ram.mem[5] !== 8'h1A || ctrl_err !== 1'b1) begin
         errors++;
         $display("FAIL conflict: got ram[5]=%h err=%b, need ram[5]=1a err=1",
                  dut.u_ram.mem[5], ctrl_err);
      end
      for (int i = 0; i < 3; i++) apply(8'h00, 1'b0, 1'b0, '0, '0, "idle");
      checks++;
      if (ctrl_err !== 1'b1) begin
         errors++; $display("FAIL err_sticky: got err=%b, need 1", ctrl_err);
      end
      apply(8'h00, 1'b1, 1'b0, '0, '0, "reset");
      checks++;
      if (ctrl_err !== 1'b0) begin
         errors++; $display("FAIL err_clear: got err=%b, need 0", ctrl_err);
      end
   endtask

   task automatic test_reset_mid();
      apply(S_RD | S_LDIR, 1'b0, 1'b0, '0, '0, "fetch");
      apply(S_RD | S_PASS | S_LDAC, 1'b0, 1'b0, '0, '0, "load");
      apply(S_INC | S_LDAC, 1'b0, 1'b0, '0, '0, "bad_ldac");
      checks++;
      if (ac !== 8'h1A || pc !== 5'd1 || ctrl_err !== 1'b1) begin
         errors++;
         $display("FAIL mid_setup: got ac=%h pc=%h err=%b, need ac=1a pc=01 err=1", ac, pc, ctrl_err);
      end
      apply(S_LDAC | S_PASS, 1'b1, 1'b1, 5'd3, 8'h77, "reset_mid");
      checks++;
      if (ac !== 8'h00 || pc !== 5'd0 || ctrl_err !== 1'b0 || dut.u_ram.mem[3] !== 8'h77) begin
         errors++;
         $display("FAIL reset_mid: got ac=%h pc=%h err=%b ram[3]=%h, need ac=00 pc=00 err=0 ram[3]=77",
                  ac, pc, ctrl_err, dut.u_ram.mem[3]);
      end
      apply(S_RD | S_LDIR, 1'b0, 1'b0, '0, '0, "refetch");
      checks++;
      if (ir !== 8'h05) begin
         errors++; $display("FAIL refetch: got ir=%h, need 05", ir);
      end
   endtask

   task automatic test_random();
      logic [7:0] legal [8];
      logic [7:0] st;
      logic rst, iwe;
      int a;
      legal = '{S_RD | S_LDIR | S_INC, S_RD | S_PASS | S_LDAC, S_RD | S_ADD | S_LDAC,
                S_WR, S_LDPC, S_INC, 8'h00, S_RD | S_LDIR};
      for (int n = 0; n < 250; n++) begin
         st  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : legal[$urandom_range(0, 7)];
         rst = ($urandom_range(0, 39) == 0);
         iwe = ($urandom_range(0, 5) == 0);
         apply(st, rst, iwe, 5'($urandom), 8'($urandom), "random");
         checks++;
         if ({pc, ir, ac, carry, ctrl_err} !== {m_pc, m_ir, m_ac, m_c, m_err}) begin
            errors++;
            $display("FAIL random_regs: got pc=%h ir=%h ac=%h c=%b err=%b, need pc=%h ir=%h ac=%h c=%b err=%b",
                     pc, ir, ac, carry, ctrl_err, m_pc, m_ir, m_ac, m_c, m_err);
         end
         a = $urandom_range(0, 31);
         checks++;
         if (dut.u_ram.mem[a] !== m_mem[a]) begin
            errors++;
            $display("FAIL random_ram: got ram[%0d]=%h, need %h", a, dut.u_ram.mem[a], m_mem[a]);
         end
      end
   endtask

   initial begin
      @(negedge clk);
      test_reset();
      test_fetch();
      test_load_add_store();
      test_jump_priority();
      test_pc_wrap();
      test_conflict();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
